regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DW, default 32: data width in bits.
REQ-002 Parameter NREGS, default 32: register count; power of two, 4..256.
REQ-003 Parameter NRD, default 2: number of read ports, 1..4.
REQ-004 Derived constant AW = log2(NREGS): address width.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 clr_req  in  1  request a full clear of the register array.
REQ-009 busy  out  1  high while a clear sweep is in progress.
REQ-010 rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
REQ-011 rd_data  out  NRD*DW  read data; port i uses bits [i*DW +: DW].
REQ-012 we_a, we_b  in  1 each  write enables for ports A and B.
REQ-013 wa_addr, wb_addr  in  AW each  write addresses for ports A and B.
REQ-014 wa_data, wb_data  in  DW each  write data for ports A and B.

Function
REQ-015 Address 0 is hardwired to zero: writes to it are discarded, and reads from it return 0 in every state.
REQ-016 Reads are combinational: rd_data[i] = mem[rd_addr[i]], with zero-latency output.
REQ-017 Writes commit on the clock edge when the enable is high, the address is nonzero, and busy is low.
REQ-018 Simultaneous A and B writes to the same address: B wins; A's write is dropped.
REQ-019 FSM states: CLEAR and READY. rst forces CLEAR with sweep index 1.
REQ-020 In CLEAR: each cycle write 0 to mem[index], then increment index; at index == NREGS-1, write it and go to READY.
REQ-021 A sweep takes NREGS-1 cycles; busy = (state == CLEAR).
REQ-022 In READY, clr_req = 1 moves the FSM to CLEAR with index 1 on the next edge; any write in that same cycle still commits and is then overwritten by the sweep.
REQ-023 clr_req is ignored while in CLEAR; the sweep is not restarted.
REQ-024 While busy, all rd_data ports return 0 and writes are ignored.
REQ-025 An rst assertion mid-sweep restarts the sweep at index 1.
REQ-026 The index counter is AW bits wide and does not wrap, because the FSM leaves CLEAR at NREGS-1.

Reset
REQ-027 While rst is high: state = CLEAR, index = 1, busy = 1, all rd_data = 0.
REQ-028 Array contents are undefined until the first sweep completes; the sweep is the only clearing mechanism.
REQ-029 After rst deasserts, busy falls after exactly NREGS-1 rising edges.

Configuration
REQ-030 Macro REGFILE_MP_BYPASS_EN.
REQ-031 Defined: read port i with nonzero rd_addr that matches an enabled write address (READY only) returns that write data in the same cycle. If both write ports match, B has priority.
REQ-032 Undefined: no forwarding; written data is visible on reads the cycle after the write edge.

Structure
REQ-033 Shared package regfile_pkg holds the FSM state enum {CLEAR, READY} and the defaults for DW, NREGS and NRD.
REQ-034 One sub-module, regfile_clr_fsm, holds the state, the index counter and busy; it outputs clr_we and clr_addr to the array.
REQ-035 The array, write arbitration and read/bypass muxing reside in regfile_mp.

Verification
REQ-036 Release rst with NREGS=32 -> busy high for exactly 31 cycles; afterwards rd_addr=5 returns 0.
REQ-037 we_a=1, wa_addr=3, wa_data=0xDEADBEEF -> rd_addr=3 reads 0xDEADBEEF in the same cycle with BYPASS_EN, or the next cycle without it.
REQ-038 we_a and we_b both to addr 7, with data 0x11 and 0x22 -> addr 7 holds 0x22; with BYPASS_EN, the same-cycle read is 0x22.
REQ-039 we_b=1, wb_addr=0, wb_data=0xFFFF -> rd_addr=0 reads 0, both in the same cycle and later.
REQ-040 Fill regs 1..31, pulse clr_req, then assert we_a to addr 4 at sweep cycle 10 -> write ignored, busy for 31 cycles, then all reads return 0.
REQ-041 Assert rst at sweep index 15 -> sweep restarts and busy remains high for another 31 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the multi-port register file.
// Optional same-cycle write-to-read forwarding is enabled with REGFILE_MP_BYPASS_EN.
package regfile_pkg;

    localparam int DW_DEF    = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep controller: zeroes registers 1..NREGS-1 after reset or on request.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // NOTE: sequential state uses non-blocking assignments only; comb blocks use blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            CLEAR: begin
                if (idx_q == LAST_IDX) state_d = READY;
                else                   idx_d   = idx_q + AW'(1);
            end
            READY: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = FIRST_IDX;
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = FIRST_IDX;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == CLEAR);
        clr_we   = busy;
        clr_addr = idx_q;
    end

endmodule

// File: rtl/regfile_mp.sv
// Register file with NRD combinational read ports, two write ports (B wins) and a
// hardwired-zero register 0. Define REGFILE_MP_BYPASS_EN for same-cycle forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [AW-1:0]     wa_addr,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DW-1:0]     wa_data,
    input  logic [DW-1:0]     wb_data
);

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wa_commit, wb_commit;
    logic [DW-1:0] mem_q [NREGS];

    regfile_clr_fsm #(.NREGS(NREGS)) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A is dropped when B targets the same register in the same cycle.
    assign wb_commit = we_b && (wb_addr != '0) && !busy;
    assign wa_commit = we_a && (wa_addr != '0) && !busy && !(we_b && (wb_addr == wa_addr));

    // NOTE: the array has no reset; the clear sweep is its only initialisation.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else begin
            if (wa_commit) mem_q[wa_addr] <= wa_data;
            if (wb_commit) mem_q[wb_addr] <= wb_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            rd = mem_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
            if (we_a && (wa_addr == ra)) rd = wa_data;
            if (we_b && (wb_addr == ra)) rd = wb_data;
`endif
            // Register 0 and the whole file read as zero while a sweep runs.
            if (busy || (ra == '0)) rd = '0;
        end

        assign rd_data[i*DW +: DW] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic
// compared against an array-and-countdown reference model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW    = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int SWEEP = NREGS - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr_req;
    logic              busy;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic              we_a, we_b;
    logic [AW-1:0]     wa_addr, wb_addr;
    logic [DW-1:0]     wa_data, wb_data;

    logic [AW-1:0] ra [NRD];
    logic [DW-1:0] ref_mem [NREGS];
    int            sweep_left;
    int            pass_cnt  = 0;
    int            total_cnt = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DW(DW), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .we_a    (we_a),
        .we_b    (we_b),
        .wa_addr (wa_addr),
        .wb_addr (wb_addr),
        .wa_data (wa_data),
        .wb_data (wb_data)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (rst || sweep_left > 0 || a == '0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
        if (we_b && wb_addr == a) return wb_data;
        if (we_a && wa_addr == a) return wa_data;
`endif
        return ref_mem[a];
    endfunction

    // Reference behaviour at one rising edge, from the inputs held across it.
    task automatic model_edge();
        if (rst) begin
            sweep_left = SWEEP;
            ref_mem[1] = '0;
        end else if (sweep_left > 0) begin
            ref_mem[NREGS - sweep_left] = '0;
            sweep_left--;
        end else begin
            if (we_a && wa_addr != '0) ref_mem[wa_addr] = wa_data;
            if (we_b && wb_addr != '0) ref_mem[wb_addr] = wb_data;
            if (clr_req) sweep_left = SWEEP;
        end
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 time unit later.
    task automatic cycle(input string tag);
        for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = ra[p];
        #1;
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, (rst || sweep_left > 0)});
        for (int p = 0; p < NRD; p++)
            check($sformatf("%s.rd%0d[%0d]", tag, p, ra[p]), rd_data[p*DW +: DW], exp_rd(ra[p]));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        we_a = 1'b0; we_b = 1'b0; clr_req = 1'b0;
        wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
    endtask

    task automatic rand_stim(input int clr_odds);
        we_a    = 1'($urandom_range(0, 1));
        we_b    = 1'($urandom_range(0, 1));
        wa_addr = AW'($urandom_range(0, NREGS - 1));
        wb_addr = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, NREGS - 1));
        wa_data = $urandom;
        wb_data = $urandom;
        clr_req = (clr_odds > 0) && ($urandom_range(1, clr_odds) == 1);
        for (int p = 0; p < NRD; p++)
            ra[p] = ($urandom_range(0, 2) == 0) ? wa_addr : AW'($urandom_range(0, NREGS - 1));
    endtask

    // Count cycles with busy high; optionally inject a port-A write at one sweep cycle.
    task automatic run_sweep(input string tag, input int inject_at);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            rand_stim(4);
            if (n == inject_at) begin
                we_a = 1'b1; wa_addr = AW'(4); wa_data = 32'hA5A5_A5A5; we_b = 1'b0;
            end
            cycle(tag);
            n++;
        end
        idle();
        check({tag, ".busy_cycles"}, 32'(n), 32'(SWEEP));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        sweep_left = SWEEP;
        for (int i = 0; i < NREGS; i++) ref_mem[i] = '0;
        for (int p = 0; p < NRD; p++) ra[p] = AW'(p + 5);

        // Reset held: busy high and reads zero, even with writes requested.
        for (int k = 0; k < 3; k++) begin
            rand_stim(2);
            cycle("reset");
        end
        idle();
        rst = 1'b0;

        // First sweep after reset, then register 5 reads zero.
        run_sweep("init_sweep", -1);
        ra[0] = AW'(5); ra[1] = AW'(0);
        cycle("post_init");

        // Single write on A, visible on reads (same cycle only with forwarding).
        we_a = 1'b1; wa_addr = AW'(3); wa_data = 32'hDEAD_BEEF;
        ra[0] = AW'(3); ra[1] = AW'(3);
        cycle("wr_a3");
        idle();
        cycle("rd_a3");
        check("rd_a3.const", rd_data[DW-1:0], 32'hDEAD_BEEF);

        // A and B collide on register 7: B wins.
        we_a = 1'b1; wa_addr = AW'(7); wa_data = 32'h11;
        we_b = 1'b1; wb_addr = AW'(7); wb_data = 32'h22;
        ra[0] = AW'(7); ra[1] = AW'(3);
        cycle("wr_ab7");
        idle();
        cycle("rd_ab7");
        check("rd_ab7.const", rd_data[DW-1:0], 32'h22);

        // Write to register 0 is discarded.
        we_b = 1'b1; wb_addr = '0; wb_data = 32'hFFFF;
        ra[0] = '0; ra[1] = '0;
        cycle("wr_b0");
        idle();
        cycle("rd_b0");
        check("rd_b0.const", rd_data[DW +: DW], '0);

        // Random traffic including occasional clear requests.
        for (int k = 0; k < 300; k++) begin
            rand_stim(40);
            cycle("random");
        end
        idle();
        while (sweep_left > 0) cycle("drain");

        // Fill every register, clear, and try a write mid-sweep.
        for (int i = 1; i < NREGS; i++) begin
            we_a = 1'b1; wa_addr = AW'(i); wa_data = $urandom;
            ra[0] = AW'(i); ra[1] = AW'(i - 1);
            cycle("fill");
        end
        idle();
        clr_req = 1'b1;
        we_b = 1'b1; wb_addr = AW'(9); wb_data = 32'h9999;
        cycle("clr_req");
        idle();
        run_sweep("clr_sweep", 10);
        for (int i = 0; i < NREGS; i += 2) begin
            ra[0] = AW'(i); ra[1] = AW'(i + 1);
            cycle("after_clr");
            check("after_clr.const", rd_data[DW-1:0], '0);
        end

        // Reset asserted at sweep index 15 restarts the full sweep.
        we_a = 1'b1; wa_addr = AW'(12); wa_data = 32'h1234;
        ra[0] = AW'(12); ra[1] = AW'(1);
        cycle("pre_rst_wr");
        idle();
        clr_req = 1'b1;
        cycle("clr_req2");
        idle();
        for (int k = 0; k < 14; k++) cycle("sweep_to_15");
        #2;
        rst = 1'b1;
        sweep_left = SWEEP;
        #1;
        check("mid_rst.busy", {31'd0, busy}, 32'd1);
        check("mid_rst.rd0", rd_data[DW-1:0], '0);
        cycle("mid_rst");
        rst = 1'b0;
        run_sweep("restart_sweep", -1);
        ra[0] = AW'(12); ra[1] = AW'(31);
        cycle("post_restart");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
